poly_eval_horner: RTL and testbench

//  Parametrised successor to the fixed A*X^2+B*X+C evaluator: evaluates an unsigned polynomial
//  P(x)=a[D]*x^D+...+a[1]*x+a[0] by Horner's method, one multiply-add per clock.

---
 rtl/poly_eval_horner.sv | 108 ++++++++++
 tb/tb_poly_eval_horner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/poly_eval_horner.sv
// Unsigned polynomial evaluator using Horner's method, one multiply-add per clock.
// Coefficients (highest order first) and x are entered serially on data_in under a go press/release handshake.
module poly_eval_horner #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             keep_coef,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_result,
  output logic             result_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int IW = (DEGREE >= 4) ? 3 : (DEGREE >= 2) ? 2 : 1;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(DEGREE);
  localparam logic [IW-1:0] K_TOP   = IW'(DEGREE - 1);

  localparam logic [2:0] S_LOAD_COEF      = 3'd0;
  localparam logic [2:0] S_LOAD_COEF_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD_X         = 3'd2;
  localparam logic [2:0] S_LOAD_X_WAIT    = 3'd3;
  localparam logic [2:0] S_COMPUTE        = 3'd4;

  logic [2:0]       state;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    k;
  logic [WIDTH-1:0] coef [DEGREE+1];
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    step;

  // Full-width Horner step; bits above WIDTH flag overflow, acc keeps the wrapped low part.
  assign step = SW'(acc) * SW'(x) + SW'(coef[k]);
  assign busy = (state == S_COMPUTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LOAD_COEF;
      idx          <= IDX_TOP;
      k            <= '0;
      for (int i = 0; i <= DEGREE; i++) coef[i] <= '0;
      x            <= '0;
      acc          <= '0;
      data_result  <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        S_LOAD_COEF: begin
          if (go) begin
            coef[idx]    <= data_in;
            result_valid <= 1'b0;
            state        <= S_LOAD_COEF_WAIT;
          end
        end
        S_LOAD_COEF_WAIT: begin
          if (!go) begin
            if (idx == '0) begin
              state <= S_LOAD_X;
            end else begin
              idx   <= idx - 1'b1;
              state <= S_LOAD_COEF;
            end
          end
        end
        S_LOAD_X: begin
          if (go) begin
            x            <= data_in;
            result_valid <= 1'b0;
            state        <= S_LOAD_X_WAIT;
          end
        end
        S_LOAD_X_WAIT: begin
          if (!go) begin
            acc      <= coef[DEGREE];
            k        <= K_TOP;
            overflow <= 1'b0;
            state    <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          acc <= step[WIDTH-1:0];
          if (|step[SW-1:WIDTH]) overflow <= 1'b1;
          // Final step: publish result and pick reload path from keep_coef.
          if (k == '0) begin
            data_result  <= step[WIDTH-1:0];
            result_valid <= 1'b1;
            if (keep_coef) begin
              state <= S_LOAD_X;
            end else begin
              idx   <= IDX_TOP;
              state <= S_LOAD_COEF;
            end
          end else begin
            k <= k - 1'b1;
          end
        end
        default: state <= S_LOAD_COEF;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval_horner.sv
// Bench for poly_eval_horner: a DEGREE=2 and a DEGREE=3 instance checked every cycle against a
// transaction-level model, plus hand-computed literal results.
module tb_poly_eval_horner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       keep_coef = 1'b0;
  logic [7:0] data_in = '0;
  logic       go0 = 1'b0;
  logic       go1 = 1'b0;
  logic [7:0] res0, res1;
  logic       val0, val1, ovf0, ovf1, bsy0, bsy1;

  int  n_cmp = 0;
  int  n_fail = 0;
  bit  check_en = 1'b0;
  int  deg [2] = '{2, 3};
  int  exp_res [2] = '{0, 0};
  int  exp_val [2] = '{0, 0};
  int  exp_ovf [2] = '{0, 0};
  int  exp_busy [2] = '{0, 0};
  longint mcoef [2][8];
  longint mx [2];
  longint macc [2];
  int  busy_cur [2] = '{0, 0};
  int  busy_len [2] = '{0, 0};

  poly_eval_horner #(.WIDTH(8), .DEGREE(2)) dut2 (
    .clk(clk), .reset(reset), .go(go0), .keep_coef(keep_coef), .data_in(data_in),
    .data_result(res0), .result_valid(val0), .overflow(ovf0), .busy(bsy0)
  );

  poly_eval_horner #(.WIDTH(8), .DEGREE(3)) dut3 (
    .clk(clk), .reset(reset), .go(go1), .keep_coef(keep_coef), .data_in(data_in),
    .data_result(res1), .result_valid(val1), .overflow(ovf1), .busy(bsy1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model expectations.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("d2_result", int'(res0), exp_res[0]);
      checkOutput("d2_valid", int'(val0), exp_val[0]);
      checkOutput("d2_overflow", int'(ovf0), exp_ovf[0]);
      checkOutput("d2_busy", int'(bsy0), exp_busy[0]);
      checkOutput("d3_result", int'(res1), exp_res[1]);
      checkOutput("d3_valid", int'(val1), exp_val[1]);
      checkOutput("d3_overflow", int'(ovf1), exp_ovf[1]);
      checkOutput("d3_busy", int'(bsy1), exp_busy[1]);
    end
  end

  always @(negedge clk) begin
    if (bsy0) busy_cur[0]++;
    else if (busy_cur[0] != 0) begin busy_len[0] = busy_cur[0]; busy_cur[0] = 0; end
    if (bsy1) busy_cur[1]++;
    else if (busy_cur[1] != 0) begin busy_len[1] = busy_cur[1]; busy_cur[1] = 0; end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_go(input int d, input logic v);
    if (d == 0) go0 = v;
    else go1 = v;
  endtask

  // P(x) as a plain power sum, reduced mod 256.
  function automatic int model_result(input int d);
    longint sum = 0;
    longint p = 1;
    for (int i = 0; i <= deg[d]; i++) begin
      sum += mcoef[d][i] * p;
      p *= mx[d];
    end
    return int'(sum % 256);
  endfunction

  task automatic applyStimulus(input int d, input int v, input int hold, input int slot);
    data_in = 8'(v);
    set_go(d, 1'b1);
    tick;
    exp_val[d] = 0;
    mcoef[d][slot] = v;
    repeat (hold - 1) tick;
    set_go(d, 1'b0);
    tick;
  endtask

  task automatic load_coefs(input int d, input int a3, input int a2, input int a1, input int a0);
    int tmp [4];
    tmp = '{a0, a1, a2, a3};
    for (int i = deg[d]; i >= 0; i--) applyStimulus(d, tmp[i], 1, i);
  endtask

  task automatic press_x(input int d, input int v);
    data_in = 8'(v);
    set_go(d, 1'b1);
    tick;
    exp_val[d] = 0;
    mx[d] = v;
    set_go(d, 1'b0);
    tick;
    exp_busy[d] = 1;
    exp_ovf[d] = 0;
    macc[d] = mcoef[d][deg[d]];
  endtask

  // keep_coef is driven inverted on non-final cycles so only the last sample matters.
  task automatic run_compute(input int d, input bit keep, input bit toggle_go);
    longint v;
    for (int s = deg[d] - 1; s >= 0; s--) begin
      if (s == 0) begin
        keep_coef = keep;
        set_go(d, 1'b0);
      end else begin
        keep_coef = !keep;
        if (toggle_go) set_go(d, (s % 2) == 1);
      end
      tick;
      v = macc[d] * mx[d] + mcoef[d][s];
      if (v >= 256) exp_ovf[d] = 1;
      macc[d] = v % 256;
      if (s == 0) begin
        exp_busy[d] = 0;
        exp_val[d] = 1;
        exp_res[d] = model_result(d);
      end
    end
    keep_coef = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) mcoef[d][i] = 0;
      mx[d] = 0;
      macc[d] = 0;
    end
    reset = 1'b1;
    tick;
    check_en = 1'b1;
    tick;
    checkOutput("reset_result", int'(res0), 0);
    checkOutput("reset_busy", int'(bsy0), 0);
    reset = 1'b0;
    tick;

    $display("[TB] test 1: 2x^2+3x+4 at x=5");
    load_coefs(0, 0, 2, 3, 4);
    press_x(0, 5);
    run_compute(0, 1'b1, 1'b0);
    @(negedge clk); #1;
    checkOutput("t1_result", int'(res0), 69);
    checkOutput("t1_overflow", int'(ovf0), 0);
    checkOutput("t1_busy_cycles", busy_len[0], 2);

    $display("[TB] test 2: reuse coefficients, x=2");
    press_x(0, 2);
    run_compute(0, 1'b0, 1'b0);
    checkOutput("t2_result", int'(res0), 18);

    $display("[TB] test 3: overflow at x=20, then x=1");
    load_coefs(0, 0, 2, 3, 4);
    press_x(0, 20);
    run_compute(0, 1'b1, 1'b0);
    checkOutput("t3_result", int'(res0), 96);
    checkOutput("t3_overflow", int'(ovf0), 1);
    press_x(0, 1);
    run_compute(0, 1'b0, 1'b0);
    checkOutput("t3b_result", int'(res0), 9);
    checkOutput("t3b_overflow", int'(ovf0), 0);

    $display("[TB] test 4: held go on a[2], go toggling in compute");
    applyStimulus(0, 1, 5, 2);
    applyStimulus(0, 2, 1, 1);
    applyStimulus(0, 3, 1, 0);
    press_x(0, 4);
    run_compute(0, 1'b0, 1'b1);
    checkOutput("t4_result", int'(res0), 27);

    $display("[TB] test 5: reset during second compute cycle");
    load_coefs(0, 0, 1, 1, 1);
    press_x(0, 2);
    tick;
    reset = 1'b1;
    tick;
    for (int d = 0; d < 2; d++) begin
      exp_res[d] = 0; exp_val[d] = 0; exp_ovf[d] = 0; exp_busy[d] = 0;
      for (int i = 0; i < 8; i++) mcoef[d][i] = 0;
    end
    reset = 1'b0;
    checkOutput("t5_result", int'(res0), 0);
    checkOutput("t5_valid", int'(val0), 0);
    checkOutput("t5_busy", int'(bsy0), 0);
    load_coefs(0, 0, 1, 2, 3);
    press_x(0, 2);
    run_compute(0, 1'b0, 1'b0);
    checkOutput("t5_after_result", int'(res0), 11);

    $display("[TB] test 6: DEGREE=3, x^3 at x=3");
    load_coefs(1, 1, 0, 0, 0);
    press_x(1, 3);
    run_compute(1, 1'b0, 1'b0);
    @(negedge clk); #1;
    checkOutput("t6_result", int'(res1), 27);
    checkOutput("t6_busy_cycles", busy_len[1], 3);

    tick;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
